// File: rtl/spi_slave_vip_pkg.sv
// Shared opcodes and FSM state encoding for the SPI responder model.
package spi_slave_vip_pkg;

    localparam logic [7:0] CMD_WR_STD  = 8'h02;
    localparam logic [7:0] CMD_WR_QUAD = 8'h32;
    localparam logic [7:0] CMD_RD_STD  = 8'h03;
    localparam logic [7:0] CMD_RD_QUAD = 8'h6B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_e;

    function automatic logic cmd_known(input logic [7:0] c);
        return c inside {CMD_WR_STD, CMD_WR_QUAD, CMD_RD_STD, CMD_RD_QUAD};
    endfunction

endpackage

// File: rtl/spi_slave_vip_sync.sv
// Two-flop synchronizer with an extra history stage; q_o is delayed to line up
// with the registered rise/fall strobes.
module spi_slave_vip_sync #(
    parameter int           W       = 1,
    parameter bit           EDGES   = 1'b1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic [W-1:0] rise_o,
    output logic [W-1:0] fall_o
);
    logic [W-1:0] meta_q, sync_q, prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign q_o = prev_q;

    generate
        if (EDGES) begin : g_edge
            logic [W-1:0] rise_q, fall_q;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    rise_q <= '0;
                    fall_q <= '0;
                end else begin
                    rise_q <= sync_q & ~prev_q;
                    fall_q <= ~sync_q & prev_q;
                end
            end
            assign rise_o = rise_q;
            assign fall_o = fall_q;
        end else begin : g_noedge
            assign rise_o = '0;
            assign fall_o = '0;
        end
    endgenerate

endmodule

// File: rtl/spi_slave_vip.sv
// Oversampled SPI mode-0 responder (std/quad) backed by a 256-byte flop memory
// with a combinational back-door read port.
module spi_slave_vip #(
    parameter int DUMMY_CYCLES = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       spi_csn_i,
    input  logic       spi_sck_i,
    input  logic [3:0] spi_sdio_i,
    output logic [3:0] spi_sdio_o,
    output logic [3:0] spi_sdio_oe_o,
    output logic       busy_o,
    output logic       cmd_err_o,
    input  logic [7:0] bd_addr_i,
    output logic [7:0] bd_rdata_o
);
    import spi_slave_vip_pkg::*;

    localparam logic [3:0] DC = 4'(DUMMY_CYCLES);

    logic       sck_r, sck_f, csn_s, csn_r, csn_f;
    logic [3:0] sio_s;

    spi_slave_vip_sync #(.W(1), .EDGES(1'b1), .RST_VAL(1'b0)) u_sck (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_sck_i),
        .q_o(), .rise_o(sck_r), .fall_o(sck_f));
    spi_slave_vip_sync #(.W(1), .EDGES(1'b1), .RST_VAL(1'b1)) u_csn (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_csn_i),
        .q_o(csn_s), .rise_o(csn_r), .fall_o(csn_f));
    spi_slave_vip_sync #(.W(4), .EDGES(1'b0), .RST_VAL(4'h0)) u_sio (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_sdio_i),
        .q_o(sio_s), .rise_o(), .fall_o());

    state_e     state_q, state_d;
    logic [7:0] cmd_q, cmd_d, addr_q, addr_d, rx_q, rx_d, tx_q, tx_d;
    logic [3:0] cnt_q, cnt_d, sdio_q, sdio_d, oe_q, oe_d;
    logic       err_q, err_d, we, load, quad, is_wr;
    logic [3:0] last;
    logic [7:0] mem_q [256];

    assign quad  = (cmd_q == CMD_WR_QUAD) || (cmd_q == CMD_RD_QUAD);
    assign is_wr = (cmd_q == CMD_WR_STD) || (cmd_q == CMD_WR_QUAD);
    assign last  = quad ? 4'd1 : 4'd7;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        sdio_d  = sdio_q;
        err_d   = 1'b0;
        we      = 1'b0;
        load    = 1'b0;
        if (csn_r) begin
            state_d = ST_IDLE;
            sdio_d  = '0;
        end else if (state_q == ST_IDLE) begin
            if (csn_f) begin
                state_d = ST_CMD;
                cnt_d   = '0;
            end
        end else if (!csn_s && sck_r) begin
            case (state_q)
                ST_CMD, ST_ADDR: begin
                    // ADDR with cnt 8 means "read address done, waiting for the loading fall"
                    if (cnt_q < 4'd8) begin
                        rx_d  = {rx_q[6:0], sio_s[0]};
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = '0;
                            if (state_q == ST_CMD) begin
                                cmd_d = rx_d;
                                if (cmd_known(rx_d)) begin
                                    state_d = ST_ADDR;
                                end else begin
                                    state_d = ST_IGNORE;
                                    err_d   = 1'b1;
                                end
                            end else begin
                                addr_d = rx_d;
                                if (is_wr)                                 state_d = ST_WDATA;
                                else if (cmd_q == CMD_RD_QUAD && DC != 0) state_d = ST_DUMMY;
                                else                                       cnt_d   = 4'd8;
                            end
                        end
                    end
                end
                ST_DUMMY: if (cnt_q != DC) cnt_d = cnt_q + 4'd1;
                ST_WDATA: begin
                    rx_d = quad ? {rx_q[3:0], sio_s} : {rx_q[6:0], sio_s[0]};
                    if (cnt_q == last) begin
                        we     = 1'b1;
                        addr_d = addr_q + 8'd1;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end else if (!csn_s && sck_f) begin
            load = (state_q == ST_ADDR  && cnt_q == 4'd8) ||
                   (state_q == ST_DUMMY && cnt_q == DC)   ||
                   (state_q == ST_RDATA && cnt_q == 4'd0);
            if (load) begin
                state_d = ST_RDATA;
                tx_d    = mem_q[addr_q];
                addr_d  = addr_q + 8'd1;
                cnt_d   = 4'd1;
            end else if (state_q == ST_RDATA) begin
                tx_d  = quad ? {tx_q[3:0], 4'h0} : {tx_q[6:0], 1'b0};
                cnt_d = (cnt_q == last) ? 4'd0 : cnt_q + 4'd1;
            end
            if (state_d == ST_RDATA)
                sdio_d = quad ? tx_d[7:4] : {2'b00, tx_d[7], 1'b0};
        end
        oe_d = (state_d != ST_RDATA) ? 4'h0 : (quad ? 4'hF : 4'h2);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            sdio_q  <= '0;
            oe_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            sdio_q  <= sdio_d;
            oe_q    <= oe_d;
            err_q   <= err_d;
        end
    end

    // Memory content survives reset on purpose.
    always_ff @(posedge clk_i) begin
        if (we) mem_q[addr_q] <= rx_d;
    end

    assign spi_sdio_o    = sdio_q;
    assign spi_sdio_oe_o = oe_q;
    assign busy_o        = ~csn_s;
    assign cmd_err_o     = err_q;
    assign bd_rdata_o    = mem_q[bd_addr_i];

endmodule

// File: tb/tb_spi_slave_vip.sv
// Bench for spi_slave_vip: directed vector table, random transactions against a
// byte-array memory model, plus abort and mid-read reset sequences.
module tb_spi_slave_vip;
    localparam int HALF = 8;

    logic       clk = 1'b0, rst = 1'b1, csn = 1'b1, sck = 1'b0;
    logic [3:0] sdio_i = 4'h0;
    logic [3:0] sdio_o, sdio_oe;
    logic       busy, cerr;
    logic [7:0] bd_addr = 8'h00;
    logic [7:0] bd_rdata;

    always #5 clk = ~clk;

    spi_slave_vip #(.DUMMY_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst), .spi_csn_i(csn), .spi_sck_i(sck),
        .spi_sdio_i(sdio_i), .spi_sdio_o(sdio_o), .spi_sdio_oe_o(sdio_oe),
        .busy_o(busy), .cmd_err_o(cerr), .bd_addr_i(bd_addr), .bd_rdata_o(bd_rdata));

    int         n_checks = 0, n_fail = 0, err_pulses = 0;
    logic [7:0] ref_mem [256];
    logic [7:0] wbuf [256];
    logic [7:0] rbuf [256];
    logic       oe_bad;

    always @(negedge clk) if (cerr) err_pulses++;

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached, got no completion, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic sck_cycle(input logic [3:0] sio, output logic [3:0] smp, output logic [3:0] oe);
        sdio_i = sio;
        repeat (HALF) @(negedge clk);
        smp = sdio_o;
        oe  = sdio_oe;
        sck = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic send8(input logic [7:0] b);
        logic [3:0] smp, oe;
        for (int i = 7; i >= 0; i--) begin
            sck_cycle({3'b000, b[i]}, smp, oe);
            if (oe !== 4'h0) oe_bad = 1'b1;
        end
    endtask

    // Full transaction: data bytes come from wbuf, captured read bytes go to rbuf.
    task automatic xfer(input logic [7:0] cmd, input logic [7:0] addr, input int n);
        logic [3:0] smp, oe, mask;
        logic       quad, rd;
        logic [7:0] b, r;
        rd   = (cmd == 8'h03) || (cmd == 8'h6B);
        quad = (cmd == 8'h32) || (cmd == 8'h6B);
        mask = (cmd == 8'h03) ? 4'h2 : (cmd == 8'h6B) ? 4'hF : 4'h0;
        oe_bad = 1'b0;
        csn = 1'b0;
        repeat (HALF) @(negedge clk);
        send8(cmd);
        send8(addr);
        if (cmd == 8'h6B)
            for (int d = 0; d < 8; d++) begin
                sck_cycle(4'($urandom), smp, oe);
                if (oe !== 4'h0) oe_bad = 1'b1;
            end
        for (int k = 0; k < n; k++) begin
            b = wbuf[k];
            r = 8'h00;
            if (quad) begin
                for (int j = 1; j >= 0; j--) begin
                    sck_cycle(b[j*4 +: 4], smp, oe);
                    r = {r[3:0], smp};
                    if (oe !== (rd ? mask : 4'h0)) oe_bad = 1'b1;
                end
            end else begin
                for (int j = 7; j >= 0; j--) begin
                    sck_cycle({3'b000, b[j]}, smp, oe);
                    r = {r[6:0], smp[1]};
                    if (oe !== (rd ? mask : 4'h0)) oe_bad = 1'b1;
                end
            end
            rbuf[k] = r;
        end
        repeat (HALF) @(negedge clk);
        csn = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic bd_read(input logic [7:0] a, output logic [7:0] d);
        bd_addr = a;
        @(negedge clk);
        d = bd_rdata;
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        int          n;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_err;
    } vec_t;

    initial begin
        vec_t       vt [10];
        logic [7:0] ops [5];
        logic [7:0] c, a, d;
        logic [3:0] smp, oe;
        int         e0, n;
        bit         is_wr, is_rd;

        vt[0] = '{8'h02, 8'h10, 2, 32'hA53C_0000, 32'h0,         0};
        vt[1] = '{8'h32, 8'hFF, 2, 32'h1234_0000, 32'h0,         0};
        vt[2] = '{8'h03, 8'h10, 2, 32'h0,         32'hA53C_0000, 0};
        vt[3] = '{8'h6B, 8'h10, 2, 32'h0,         32'hA53C_0000, 0};
        vt[4] = '{8'h03, 8'hFF, 2, 32'h0,         32'h1234_0000, 0};
        vt[5] = '{8'h02, 8'h20, 2, 32'h5A6B_0000, 32'h0,         0};
        vt[6] = '{8'h9F, 8'h20, 2, 32'hDEAD_0000, 32'h0,         1};
        vt[7] = '{8'h03, 8'h20, 2, 32'h0,         32'h5A6B_0000, 0};
        vt[8] = '{8'h32, 8'h80, 4, 32'hCAFE_F00D, 32'h0,         0};
        vt[9] = '{8'h6B, 8'h80, 4, 32'h0,         32'hCAFE_F00D, 0};
        ops   = '{8'h02, 8'h32, 8'h03, 8'h6B, 8'h9F};

        repeat (4) @(negedge clk);
        check("reset_outputs", {sdio_o, sdio_oe, 2'b00, busy, cerr}, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Preload every location so the model knows the whole memory.
        for (int i = 0; i < 256; i++) wbuf[i] = 8'($urandom);
        xfer(8'h32, 8'h00, 256);
        for (int i = 0; i < 256; i++) ref_mem[i] = wbuf[i];
        for (int i = 0; i < 256; i++) begin
            bd_read(8'(i), d);
            check("preload_bd", d, ref_mem[i]);
        end

        for (int v = 0; v < 10; v++) begin
            for (int k = 0; k < vt[v].n; k++) wbuf[k] = vt[v].wd[31-8*k -: 8];
            e0 = err_pulses;
            xfer(vt[v].cmd, vt[v].addr, vt[v].n);
            check("vec_err_pulses", err_pulses - e0, vt[v].exp_err);
            check("vec_oe_phase", oe_bad, 1'b0);
            check("vec_idle_after", {busy, sdio_oe}, 32'h0);
            for (int k = 0; k < vt[v].n; k++) begin
                a = vt[v].addr + 8'(k);
                if (vt[v].cmd == 8'h02 || vt[v].cmd == 8'h32) begin
                    ref_mem[a] = vt[v].wd[31-8*k -: 8];
                    bd_read(a, d);
                    check("vec_bd_write", d, vt[v].wd[31-8*k -: 8]);
                end else if (vt[v].cmd == 8'h9F) begin
                    bd_read(a, d);
                    check("vec_bd_unchanged", d, ref_mem[a]);
                end else begin
                    check("vec_read_data", rbuf[k], vt[v].exp_rd[31-8*k -: 8]);
                end
            end
        end

        for (int t = 0; t < 16; t++) begin
            c = ops[$urandom_range(0, 4)];
            a = 8'($urandom);
            n = int'($urandom_range(1, 4));
            for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
            is_wr = (c == 8'h02) || (c == 8'h32);
            is_rd = (c == 8'h03) || (c == 8'h6B);
            e0 = err_pulses;
            xfer(c, a, n);
            check("rnd_err_pulses", err_pulses - e0, (c == 8'h9F) ? 1 : 0);
            check("rnd_oe_phase", oe_bad, 1'b0);
            for (int k = 0; k < n; k++) begin
                if (is_wr) ref_mem[8'(a + 8'(k))] = wbuf[k];
                if (is_rd) begin
                    check("rnd_read_data", rbuf[k], ref_mem[8'(a + 8'(k))]);
                end else begin
                    bd_read(a + 8'(k), d);
                    check("rnd_bd", d, ref_mem[8'(a + 8'(k))]);
                end
            end
        end

        // Abort after half a write byte: nothing may be written.
        oe_bad = 1'b0;
        csn = 1'b0;
        repeat (HALF) @(negedge clk);
        send8(8'h02);
        send8(8'h40);
        for (int i = 0; i < 4; i++) sck_cycle({3'b000, ~ref_mem[8'h40][7-i]}, smp, oe);
        repeat (HALF) @(negedge clk);
        csn = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        bd_read(8'h40, d);
        check("abort_mem_unchanged", d, ref_mem[8'h40]);
        check("abort_idle", {busy, sdio_oe}, 32'h0);
        e0 = err_pulses;
        xfer(8'h03, 8'h40, 1);
        check("abort_next_read", rbuf[0], ref_mem[8'h40]);
        check("abort_next_err", err_pulses - e0, 0);

        // Reset in the middle of a quad read.
        oe_bad = 1'b0;
        csn = 1'b0;
        repeat (HALF) @(negedge clk);
        send8(8'h6B);
        send8(8'h10);
        for (int i = 0; i < 8; i++) sck_cycle(4'h0, smp, oe);
        sck_cycle(4'h0, smp, oe);
        check("midread_oe", oe, 4'hF);
        check("midread_nibble", smp, ref_mem[8'h10][7:4]);
        #2 rst = 1'b1;
        #1;
        check("async_rst_oe", sdio_oe, 4'h0);
        check("async_rst_busy", busy, 1'b0);
        csn = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        xfer(8'h03, 8'h10, 1);
        check("post_rst_read", rbuf[0], ref_mem[8'h10]);
        check("post_rst_oe_phase", oe_bad, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_vip.md
# spi_slave_vip

Oversampled SPI responder model for the verification environment. It is the far-end device that answers the SPI master through the MSPI pad ring, in standard and quad modes. It samples SCK, CSN and SIO[3:0] with the system clock and decodes a command/address/data protocol against an internal 256-byte memory. It drives SIO lines back through per-bit output enables, and has a back-door read port so the bench can check memory contents.

## Interface
- DUMMY_CYCLES, 8: SCK cycles between the address and the data phase for quad read (0x6B); legal range 0..15.
- clk_i  in  1  system clock; must run at ≥ 8× the SCK frequency.
- rst_i  in  1  asynchronous, active-high reset.
- spi_csn_i  in  1  chip select from the CSN pad, active low.
- spi_sck_i  in  1  serial clock from the SCK pad; SPI mode 0 (idle low, sample on rise, shift on fall).
- spi_sdio_i  in  4  SIO3..SIO0 pad values.
- spi_sdio_o  out  4  data driven toward the SIO pads.
- spi_sdio_oe_o  out  4  per-bit pad drive enable.
- busy_o  out  1  high while the synchronized CSN is low.
- cmd_err_o  out  1  one-cycle pulse on an unknown command byte.
- bd_addr_i  in  8  back-door memory address.
- bd_rdata_o  out  8  combinational read of mem[bd_addr_i].

## Operation
- Input capture:
  - CSN, SCK and SIO each pass through a 2-flop synchronizer.
  - SCK rise and fall are detected from the synchronized value versus its previous value.
- States: IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, IGNORE.
- IDLE → CMD when the synchronized CSN falls.
- CMD: 8 bits, MSB first, on SIO0, one bit per SCK rise.
- After the 8th command bit the state moves to ADDR, except for an unknown opcode:
  - an unknown opcode → IGNORE and a cmd_err_o pulse;
  - IGNORE holds until CSN rises.
- Commands:
  - 0x02: std write;
  - 0x32: quad write;
  - 0x03: std read;
  - 0x6B: quad read.
- ADDR: 8 bits, MSB first, on SIO0 for every command.
- After ADDR:
  - writes → WDATA;
  - 0x03 → RDATA;
  - 0x6B → DUMMY, or straight to RDATA if DUMMY_CYCLES = 0.
- DUMMY: count SCK rises up to DUMMY_CYCLES, then → RDATA.
- WDATA:
  - std: 1 bit per rise on SIO0;
  - quad: 1 nibble per rise on SIO3..0, high nibble first, SIO3 = MSB of the nibble;
  - each completed byte writes mem[addr], then addr increments by 1, wrapping 0xFF→0x00.
- RDATA:
  - load the shift register with mem[addr] at the SCK fall that ends the previous phase, and at each byte boundary; then addr++ with wrap;
  - std: MSB out on SIO1, shifted on each SCK fall;
  - quad: high nibble out on SIO3..0, then low nibble.
- Output enables:
  - std read: spi_sdio_oe_o = 4'b0010 for the whole of RDATA;
  - quad read: 4'b1111 for the whole of RDATA;
  - 0 in every other state.
- CSN rise (synchronized) in any state → IDLE in the next cycle, with oe = 0.
  - A partially received write byte is discarded.
  - A partially shifted read byte is dropped.
  - The address is not retained across transactions.
- Memory is flops and is not cleared by reset.

## Timing
- Reset values: spi_sdio_o = 0, spi_sdio_oe_o = 0, busy_o = 0, cmd_err_o = 0, state = IDLE.
- SCK edge to internal action: 3 clk_i cycles (2 sync + 1 edge register).
- The same latency applies to CSN.
- Output bit/oe update: registered, 1 cycle after the internal fall detect, i.e. 4 cycles after the pad edge.
- The first read bit is valid before the first data-phase SCK rise.
- Memory write: takes effect in the cycle after the byte-completing rise is detected.
  - bd_rdata_o reflects it 1 cycle later.
- cmd_err_o: asserted in the cycle after the 8th command bit is detected.
- If CSN rises and an SCK edge is detected in the same cycle, CSN wins and the edge is ignored.
- An SCK edge while the synchronized CSN is high is ignored.

## Structure
- Package spi_slave_vip_pkg:
  - opcode constants CMD_WR_STD, CMD_WR_QUAD, CMD_RD_STD, CMD_RD_QUAD;
  - state enum typedef.
- Sub-module spi_slave_vip_sync: parameterizable-width 2-flop synchronizer with registered rise/fall outputs; instantiated for SCK and CSN, and for SIO without the edge outputs.

## Test plan
- Std write 0x02, addr 0x10, data 0xA5 0x3C, CSN high → bd reads mem[0x10] = 0xA5 and mem[0x11] = 0x3C; oe stays 0.
- Quad write 0x32, addr 0xFF, data 0x12 0x34 → mem[0xFF] = 0x12 and mem[0x00] = 0x34 (address wrap).
- Std read 0x03, addr 0x10 after the first test → SIO1 shows 0xA5 then 0x3C MSB first; oe = 4'b0010 only during data.
- Quad read 0x6B, addr 0x10, 8 dummy clocks → nibbles A,5,3,C on SIO3..0; oe = 4'b1111 from the 8th dummy fall until CSN rises.
- Opcode 0x9F → cmd_err_o pulses once; following clocks cause no memory change and oe stays 0.
- Abort: CSN rises after 4 bits of a write byte → memory unchanged and state IDLE. rst_i asserted mid-read → oe = 0 immediately (asynchronous), busy_o = 0.
